// File: rtl/ws2811_link_master.sv
// ws2811_link_master
//
// Sends one 56-bit WS2811-style frame down a satellite chain and collects
// the 16-bit reply that comes back around the loop.
//
// Frame on the wire, MSB first:
//   cmd[3:0], mode[11:0], actuatorData[31:0], 4'b0000, crc4[3:0]
// The CRC uses x^4+x+1, starts at 0, runs over the first 52 bits and is
// not inverted. The frame ends with a low latch period.
//
// Ports
//   masterClk      system clock, rising edge
//   nReset         asynchronous active-low reset
//   start          frame request, taken only while idle
//   cmd            command nibble
//   mode           four 3-bit actuator modes
//   actuatorData   four 8-bit actuator values
//   ws2811wireOut  line to the first satellite
//   ws2811wireIn   line back from the chain (asynchronous)
//   busy           frame in progress
//   done           one-cycle pulse at end of frame
//   sensorData     last good sensor byte received
//   feedback       last good feedback nibble (bit0 = remote CRC error)
//   crcRxErr       CRC mismatch on the last reply
//   rxTimeout      last reply had fewer than 16 bits
module ws2811_link_master #(
    parameter int unsigned BIT_CYC    = 60,
    parameter int unsigned T0H_CYC    = 19,
    parameter int unsigned T1H_CYC    = 38,
    parameter int unsigned THRESH_CYC = 28,
    parameter int unsigned RESET_CYC  = 2400
) (
    input  logic        masterClk,
    input  logic        nReset,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [11:0] mode,
    input  logic [31:0] actuatorData,
    output logic        ws2811wireOut,
    input  logic        ws2811wireIn,
    output logic        busy,
    output logic        done,
    output logic [7:0]  sensorData,
    output logic [3:0]  feedback,
    output logic        crcRxErr,
    output logic        rxTimeout
);

    // One counter covers both the bit period and the latch period.
    localparam int unsigned MaxCyc = (RESET_CYC > BIT_CYC) ? RESET_CYC : BIT_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] BitLast   = CntW'(BIT_CYC - 1);
    localparam logic [CntW-1:0] LatchLast = CntW'(RESET_CYC - 1);
    localparam logic [CntW-1:0] T0hTime   = CntW'(T0H_CYC);
    localparam logic [CntW-1:0] T1hTime   = CntW'(T1H_CYC);

    localparam logic [5:0] LastBit  = 6'd55;
    localparam logic [4:0] RxBits   = 5'd16;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StLatch
    } state_e;

    // ------------------------------------------------------------------
    // CRC helpers: serial x^4+x+1, one message bit per step.
    // ------------------------------------------------------------------
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
        logic fb;
        fb = crc[3] ^ din;
        return {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    endfunction

    function automatic logic [3:0] crc4_52(input logic [51:0] msg);
        logic [3:0] crc;
        crc = 4'b0000;
        for (int i = 51; i >= 0; i--) begin
            crc = crc4_step(crc, msg[i]);
        end
        return crc;
    endfunction

    function automatic logic [3:0] crc4_12(input logic [11:0] msg);
        logic [3:0] crc;
        crc = 4'b0000;
        for (int i = 11; i >= 0; i--) begin
            crc = crc4_step(crc, msg[i]);
        end
        return crc;
    endfunction

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      bit_idx_q, bit_idx_d;
    logic [55:0]     tx_q, tx_d;
    logic            wire_out_q, wire_out_d;
    logic            done_q, done_d;
    logic [51:0]     tx_msg;

    assign tx_msg = {cmd, mode, actuatorData, 4'b0000};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                // A start seen while done is still high is dropped; it is
                // picked up on the following cycle if still asserted.
                if (start && !done_q) begin
                    state_d   = StSend;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = {tx_msg, crc4_52(tx_msg)};
                end
            end
            StSend: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (bit_idx_q == LastBit) begin
                        state_d = StLatch;
                    end else begin
                        bit_idx_d = bit_idx_q + 6'd1;
                        tx_d      = {tx_q[54:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                if (cnt_q == LatchLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Line level is registered from next-state values so the output pin
        // is glitch-free and leads the bit by exactly one edge.
        wire_out_d = (state_d == StSend) && (cnt_d < (tx_d[55] ? T1hTime : T0hTime));
    end

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            tx_q       <= '0;
            wire_out_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            wire_out_q <= wire_out_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]  sync_q;
    logic        rx_prev_q;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [4:0]  rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_sh_q, rx_sh_d;
    logic        rx_line;
    logic        rx_fall;
    logic        rx_bit;

    assign rx_line = sync_q[1];
    assign rx_fall = rx_prev_q && !rx_line;
    assign rx_bit  = {24'd0, hcnt_q} > THRESH_CYC;

    always_comb begin
        hcnt_d   = hcnt_q;
        rx_cnt_d = rx_cnt_q;
        rx_sh_d  = rx_sh_q;

        if (state_q == StIdle) begin
            // Disarmed: any pulse still high after the latch is thrown away
            // and the next frame starts from an empty reply buffer.
            hcnt_d   = '0;
            rx_cnt_d = '0;
            rx_sh_d  = '0;
        end else if (rx_line) begin
            if (hcnt_q != 8'hFF) begin
                hcnt_d = hcnt_q + 8'd1;
            end
        end else if (rx_fall) begin
            hcnt_d = '0;
            if (rx_cnt_q != RxBits) begin
                rx_sh_d  = {rx_sh_q[14:0], rx_bit};
                rx_cnt_d = rx_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            sync_q    <= '0;
            rx_prev_q <= 1'b0;
            hcnt_q    <= '0;
            rx_cnt_q  <= '0;
            rx_sh_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], ws2811wireIn};
            rx_prev_q <= rx_line;
            hcnt_q    <= hcnt_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_sh_q   <= rx_sh_d;
        end
    end

    // ------------------------------------------------------------------
    // Reply status, updated once per frame on the done edge
    // ------------------------------------------------------------------
    logic [7:0] sensor_q, sensor_d;
    logic [3:0] fb_q, fb_d;
    logic       crc_err_q, crc_err_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        sensor_d  = sensor_q;
        fb_d      = fb_q;
        crc_err_d = crc_err_q;
        timeout_d = timeout_q;

        // Next-state receive values are used so a bit decoded on the very
        // edge that closes the frame is still counted.
        if (done_d) begin
            if (rx_cnt_d == RxBits) begin
                crc_err_d = (crc4_12(rx_sh_d[15:4]) != rx_sh_d[3:0]);
                timeout_d = 1'b0;
                if (!crc_err_d) begin
                    sensor_d = rx_sh_d[15:8];
                    fb_d     = rx_sh_d[7:4];
                end
            end else begin
                crc_err_d = 1'b0;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            sensor_q  <= '0;
            fb_q      <= '0;
            crc_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sensor_q  <= sensor_d;
            fb_q      <= fb_d;
            crc_err_q <= crc_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign ws2811wireOut = wire_out_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign sensorData    = sensor_q;
    assign feedback      = fb_q;
    assign crcRxErr      = crc_err_q;
    assign rxTimeout     = timeout_q;

endmodule

// File: tb/tb_ws2811_link_master.sv
// Testbench for ws2811_link_master: directed and randomized frames checked
// against a frame-level model (bit timing from the frame contents, CRC by
// polynomial long division, reply decode from the returned bit string).
module tb_ws2811_link_master;

    localparam int BIT     = 60;
    localparam int T0H     = 19;
    localparam int T1H     = 38;
    localparam int THR     = 28;
    localparam int RST     = 2400;
    localparam int SEND    = 56 * BIT;
    localparam int DONE_AT = 1 + SEND + RST;

    localparam int SRC_LOOP   = 0;
    localparam int SRC_INJECT = 1;
    localparam int SRC_SILENT = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cmd   = '0;
    logic [11:0] mode  = '0;
    logic [31:0] act   = '0;
    logic        wire_out;
    logic        wire_in;
    logic        busy;
    logic        done;
    logic [7:0]  sensor;
    logic [3:0]  fb;
    logic        crc_err;
    logic        rx_to;

    logic loop_en = 1'b1;
    logic inj     = 1'b0;

    assign wire_in = loop_en ? wire_out : inj;

    always #5 clk = ~clk;

    ws2811_link_master #(
        .BIT_CYC   (BIT),
        .T0H_CYC   (T0H),
        .T1H_CYC   (T1H),
        .THRESH_CYC(THR),
        .RESET_CYC (RST)
    ) dut (
        .masterClk    (clk),
        .nReset       (rst_n),
        .start        (start),
        .cmd          (cmd),
        .mode         (mode),
        .actuatorData (act),
        .ws2811wireOut(wire_out),
        .ws2811wireIn (wire_in),
        .busy         (busy),
        .done         (done),
        .sensorData   (sensor),
        .feedback     (fb),
        .crcRxErr     (crc_err),
        .rxTimeout    (rx_to)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_sensor = '0;
    logic [3:0] exp_fb     = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of msg(x)*x^4 divided by x^4+x+1, msg being the low n bits.
    function automatic logic [3:0] crc_ref(input logic [63:0] msg, input int n);
        logic [67:0] r;
        r = {msg, 4'b0000};
        for (int i = n + 3; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    // Drives return pulses: '0' = 28 high cycles, '1' = 29 (or 270 at sat_idx).
    task automatic inject(input logic [19:0] pat, input int npulse, input int sat_idx);
        int w;
        for (int i = 0; i < npulse; i++) begin
            if (pat[19 - i]) w = (i == sat_idx) ? 270 : 29;
            else             w = 28;
            inj = 1'b1;
            repeat (w) @(negedge clk);
            inj = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic run_frame(input string tag, input logic [3:0] c, input logic [11:0] m,
                             input logic [31:0] d, input int src, input int restart_at,
                             input logic [19:0] pat, input int npulse, input int sat_idx);
        logic [51:0] msg;
        logic [55:0] bits;
        logic [15:0] rx16;
        int          rx_n;
        int          wave_err;
        int          busy_err;
        int          done_cnt;
        int          done_at;
        logic        exp_w;
        logic        e_err;
        logic        e_to;

        msg  = {c, m, d, 4'b0000};
        bits = {msg, crc_ref({12'd0, msg}, 52)};
        loop_en = (src == SRC_LOOP);
        inj = 1'b0;
        wave_err = 0;
        busy_err = 0;
        done_cnt = 0;
        done_at  = -1;

        @(negedge clk);
        cmd = c; mode = m; act = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        fork
            begin
                for (int cyc = 1; cyc <= DONE_AT + 3; cyc++) begin
                    if (cyc <= SEND)
                        exp_w = ((cyc - 1) % BIT) < (bits[55 - (cyc - 1) / BIT] ? T1H : T0H);
                    else
                        exp_w = 1'b0;
                    if (wire_out !== exp_w) wave_err++;
                    if (busy !== (cyc < DONE_AT)) busy_err++;
                    if (done === 1'b1) begin
                        done_cnt++;
                        done_at = cyc;
                    end
                    start = (cyc == restart_at);
                    @(negedge clk);
                end
                start = 1'b0;
            end
            begin
                if (src == SRC_INJECT) inject(pat, npulse, sat_idx);
            end
        join

        if (src == SRC_LOOP) begin
            rx16 = bits[55:40];
            rx_n = 16;
        end else if (src == SRC_INJECT) begin
            rx16 = pat[19:4];
            rx_n = npulse;
        end else begin
            rx16 = '0;
            rx_n = 0;
        end

        if (rx_n >= 16) begin
            e_err = (crc_ref({52'd0, rx16[15:4]}, 12) != rx16[3:0]);
            e_to  = 1'b0;
            if (!e_err) begin
                exp_sensor = rx16[15:8];
                exp_fb     = rx16[7:4];
            end
        end else begin
            e_err = 1'b0;
            e_to  = 1'b1;
        end

        check({tag, ".wave_errs"}, wave_err, 0);
        check({tag, ".busy_errs"}, busy_err, 0);
        check({tag, ".done_count"}, done_cnt, 1);
        check({tag, ".done_cycle"}, done_at, DONE_AT);
        check({tag, ".crcRxErr"}, crc_err, e_err);
        check({tag, ".rxTimeout"}, rx_to, e_to);
        check({tag, ".sensorData"}, sensor, exp_sensor);
        check({tag, ".feedback"}, fb, exp_fb);
    endtask

    // Builds a mode word whose low nibble is the correct reply CRC for loopback.
    function automatic logic [11:0] valid_mode(input logic [3:0] c, input logic [7:0] hi);
        return {hi, crc_ref({52'd0, c, hi}, 12)};
    endfunction

    initial begin : main
        logic [3:0]  c;
        logic [11:0] m;
        logic [31:0] d;
        logic [19:0] pat;
        logic [11:0] word12;
        int          guard;
        int          dones;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.wireOut", wire_out, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.sensorData", sensor, 0);
        check("reset.feedback", fb, 0);
        check("reset.crcRxErr", crc_err, 0);
        check("reset.rxTimeout", rx_to, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero loopback frame
        run_frame("zero", 4'h0, 12'h000, 32'h0, SRC_LOOP, 0, '0, 0, -1);

        // Random loopback frame with a correct reply CRC
        c = 4'($urandom_range(1, 15));
        m = valid_mode(c, 8'($urandom));
        d = $urandom;
        run_frame("rand_ok", c, m, d, SRC_LOOP, 0, '0, 0, -1);

        // Reply CRC mismatch: status held
        run_frame("crc_bad", 4'b1000, 12'h000, 32'h0, SRC_LOOP, 0, '0, 0, -1);

        // Silent return line
        run_frame("silent", 4'h3, 12'h5A5, $urandom, SRC_SILENT, 0, '0, 0, -1);

        // Second start mid-frame must be ignored
        run_frame("restart", 4'($urandom), 12'($urandom), $urandom, SRC_LOOP, 100, '0, 0, -1);

        // Injected 28/29-cycle pulses, one saturating pulse, extra bits dropped
        word12 = 12'hA56;
        pat = {word12, crc_ref({52'd0, word12}, 12), 4'b1011};
        run_frame("inject", 4'h7, 12'h123, $urandom, SRC_INJECT, 0, pat, 18, 0);

        // Too few injected bits
        run_frame("short", 4'h1, 12'h0F0, $urandom, SRC_INJECT, 0, 20'hFFFFF, 10, -1);

        // start held through done: ignored in the done cycle, taken the next
        c = 4'h9;
        m = valid_mode(c, 8'h3C);
        loop_en = 1'b1;
        @(negedge clk);
        cmd = c; mode = m; act = $urandom; start = 1'b1;
        guard = 0;
        while (done !== 1'b1 && guard < DONE_AT + 10) begin
            @(negedge clk);
            guard++;
        end
        check("hold.done_seen", done, 1);
        check("hold.busy_in_done", busy, 0);
        @(negedge clk);
        check("hold.busy_after_done", busy, 0);
        @(negedge clk);
        check("hold.busy_accepted", busy, 1);
        check("hold.sensorData", sensor, {c, m[11:8]});
        start = 1'b0;

        // Reset 1000 cycles into the re-accepted frame
        repeat (999) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.wireOut", wire_out, 0);
        check("abort.busy", busy, 0);
        check("abort.sensorData", sensor, 0);
        exp_sensor = '0;
        exp_fb     = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < DONE_AT + 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        check("abort.no_done", dones, 0);

        // Clean frame after reset
        c = 4'h6;
        m = valid_mode(c, 8'hC3);
        run_frame("post_reset", c, m, $urandom, SRC_LOOP, 0, '0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2811_link_master.md
WS2811_LINK_MASTER -- requirements
Module: ws2811_link_master

Interface
REQ-001 Parameter BIT_CYC, default 60, masterClk cycles per transmitted bit period.
REQ-002 Parameter T0H_CYC, default 19, high time of a transmitted '0' bit.
REQ-003 Parameter T1H_CYC, default 38, high time of a transmitted '1' bit.
REQ-004 Parameter THRESH_CYC, default 28; a received high pulse longer than this decodes as '1'.
REQ-005 Parameter RESET_CYC, default 2400, low latch time closing a frame.
REQ-006 Ports: one clock; reset is asynchronous and active-low.
REQ-007 masterClk  in  1  system clock; all state updates on its rising edge.
REQ-008 nReset  in  1  asynchronous active-low reset.
REQ-009 start  in  1  request one frame; honoured only when busy=0.
REQ-010 cmd  in  4  command nibble.
REQ-011 mode  in  12  four 3-bit actuator modes.
REQ-012 actuatorData  in  32  four 8-bit actuator values.
REQ-013 ws2811wireOut  out  1  WS2811 line to the first satellite.
REQ-014 ws2811wireIn  in  1  WS2811 line returning from the satellite chain; asynchronous.
REQ-015 busy  out  1  frame in progress.
REQ-016 done  out  1  one-cycle pulse at end of frame.
REQ-017 sensorData  out  8  last valid received sensor byte.
REQ-018 feedback  out  4  last valid received feedback nibble; bit0 = satellite remote CRC error.
REQ-019 crcRxErr  out  1  CRC mismatch on last received frame.
REQ-020 rxTimeout  out  1  fewer than 16 bits received in last frame.

Function
REQ-021 When start=1 and busy=0 at edge k, cmd/mode/actuatorData SHALL be captured and busy SHALL be 1 from k+1; start while busy=1 SHALL be ignored.
REQ-022 TX frame SHALL be 56 bits, MSB-first: cmd[3:0], mode[11:0], actuatorData[31:0], 4'b0000, crc4[3:0].
REQ-023 crc4: polynomial x^4+x+1, init 4'b0000, computed over the first 52 bits, no final inversion.
REQ-024 FSM states IDLE -> SEND (56 bits) -> LATCH (RESET_CYC cycles) -> IDLE.
REQ-025 In SEND, each bit SHALL drive ws2811wireOut high for T0H_CYC ('0') or T1H_CYC ('1') cycles, then low for the rest of BIT_CYC; bits are back-to-back.
REQ-026 First bit's high phase SHALL begin at k+1; LATCH SHALL hold the line low for RESET_CYC cycles.
REQ-027 done SHALL pulse at cycle k+1+56*BIT_CYC+RESET_CYC, and busy SHALL fall in that same cycle.
REQ-028 ws2811wireIn SHALL pass through a 2-flop synchronizer; the receiver SHALL count synchronized high cycles and decode one bit on each falling edge.
REQ-029 Receiver SHALL be armed only while busy=1, SHALL store the first 16 decoded bits (sensor[7:0], feedback[3:0], crc[3:0], MSB-first) and ignore all later bits.
REQ-030 A high-count saturating at 255 SHALL not wrap; pulses still high when LATCH ends SHALL be discarded.
REQ-031 At done: if 16 bits were received, crcRxErr SHALL be set to (crc4 of first 12 bits != received crc), rxTimeout SHALL be set to 0, and sensorData/feedback SHALL update only if crcRxErr=0.
REQ-032 At done with fewer than 16 bits received: rxTimeout SHALL be set to 1, crcRxErr to 0, and sensorData/feedback SHALL hold.
REQ-033 start asserted in the cycle done pulses SHALL be ignored; it is accepted next cycle if still high.

Reset
REQ-034 nReset low SHALL immediately force IDLE, ws2811wireOut=0, busy=0, done=0, sensorData=0, feedback=0, crcRxErr=0, rxTimeout=0, counters and synchronizer to 0.
REQ-035 Reset mid-frame SHALL abort without a done pulse; the first frame after release starts with a clean receiver.

Verification
REQ-036 cmd=0, mode=0, actuatorData=0, wireOut looped to wireIn -> 56 pulses each 19 cycles high, crc 0000, done at k+1+5760, sensorData=8'h00, crcRxErr=0, rxTimeout=0.
REQ-037 cmd=4'b1000, rest 0, loopback -> crcRxErr=1, sensorData and feedback keep their previous values, rxTimeout=0.
REQ-038 ws2811wireIn held low -> done at k+1+5760 with rxTimeout=1, crcRxErr=0, sensorData unchanged.
REQ-039 start pulsed again at k+100 -> ignored; exactly one done pulse.
REQ-040 nReset asserted at k+1000 -> wireOut=0 and busy=0 immediately, no done; new start after release yields a correct full frame.
REQ-041 Injected return pulses of 28 and 29 high cycles -> decoded as '0' and '1' respectively.
